hs_fifo_sfifo: RTL and testbench

- Single-clock synchronous FIFO with valid/ready handshakes on both sides.
- Packet-aware: a write packet is terminated by wlast and becomes visible to the reader only once committed. An uncommitted packet can be discarded with wdrop.
- The read side can inspect the head word non-destructively with rpeek.
- Exposes an occupancy level plus almost-full and almost-empty flags. Used as the generic buffering primitive between streaming blocks.

---
 rtl/hs_fifo_sfifo.sv | 78 +++++++
 tb/tb_hs_fifo_sfifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hs_fifo_sfifo.sv
// hs_fifo_sfifo: packet-aware single-clock FIFO with commit/drop, peek and level flags.
// Occupancy and committed counts are kept as counters beside the three wrapped pointers.
module hs_fifo_sfifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   wlast,
    input  logic                   wdrop,
    output logic                   walmost_full,
    input  logic                   rready,
    output logic                   rvalid,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   rlast,
    input  logic                   rpeek,
    output logic                   ralmost_empty,
    output logic [LEVEL_WIDTH-1:0] level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = LEVEL_WIDTH;

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d, cmt_q, cmt_d;
    logic wr_en, rd_en;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_en = wvalid && wready && !wdrop;
        rd_en = rvalid && rready && !rpeek;
        wr_d  = wdrop ? cm_q : (wr_en ? inc(wr_q) : wr_q);
        cm_d  = (wr_en && wlast) ? inc(wr_q) : cm_q;
        rd_d  = rd_en ? inc(rd_q) : rd_q;
        // a drop rewinds occupancy to the committed words; a wlast write commits everything stored
        lvl_d = (wdrop ? cmt_q : lvl_q + LW'(wr_en)) - LW'(rd_en);
        cmt_d = ((wr_en && wlast) ? lvl_q + LW'(1) : cmt_q) - LW'(rd_en);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_q  <= '0;
            cm_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            cmt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            cm_q  <= cm_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
            cmt_q <= cmt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= {wlast, wdata};
    end

    always_comb begin
        wready        = lvl_q != LW'(FIFO_DEPTH);
        rvalid        = cmt_q != '0;
        rdata         = rvalid ? mem[rd_q][DATA_WIDTH-1:0] : '0;
        rlast         = rvalid ? mem[rd_q][DATA_WIDTH] : 1'b0;
        level         = lvl_q;
        walmost_full  = lvl_q >= LW'(AFULL_LEVEL);
        ralmost_empty = cmt_q <= LW'(AEMPTY_LEVEL);
    end
endmodule

// File: tb/tb_hs_fifo_sfifo.sv
// tb_hs_fifo_sfifo: directed checks of commit, drop, full/wrap, peek and async reset.
module tb_hs_fifo_sfifo;
    logic       clk = 1'b0;
    logic       areset, wvalid, wlast, wdrop, rready, rpeek;
    logic [7:0] wdata;
    logic       wready, walmost_full, rvalid, rlast, ralmost_empty;
    logic [7:0] rdata;
    logic [3:0] level;
    int         n_run = 0, n_fail = 0;

    hs_fifo_sfifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2)) dut (
        .clk(clk), .areset(areset), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wlast(wlast), .wdrop(wdrop), .walmost_full(walmost_full), .rready(rready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rpeek(rpeek),
        .ralmost_empty(ralmost_empty), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input logic l);
        wvalid = 1'b1;
        wdata  = d;
        wlast  = l;
    endtask

    initial begin
        areset = 1'b1; wvalid = 0; wlast = 0; wdrop = 0; rready = 0; rpeek = 0; wdata = 0;
        repeat (2) tick();
        check("rst_wready", wready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_level", level, 0);
        check("rst_afull", walmost_full, 0);
        check("rst_aempty", ralmost_empty, 1);
        check("rst_rdata", rdata, 0);
        areset = 1'b0;
        tick();

        // three-word packet, reader always ready
        rready = 1'b1;
        put(8'h11, 0); tick();
        check("p1_rvalid_a", rvalid, 0); check("p1_level_a", level, 1);
        put(8'h22, 0); tick();
        check("p1_rvalid_b", rvalid, 0); check("p1_level_b", level, 2);
        put(8'h33, 1); tick();
        wvalid = 0; wlast = 0;
        check("p1_rvalid_c", rvalid, 1); check("p1_level_c", level, 3);
        check("p1_d0", rdata, 8'h11); check("p1_l0", rlast, 0);
        tick();
        check("p1_d1", rdata, 8'h22); check("p1_l1", rlast, 0); check("p1_level_d", level, 2);
        tick();
        check("p1_d2", rdata, 8'h33); check("p1_l2", rlast, 1); check("p1_level_e", level, 1);
        tick();
        check("p1_empty", rvalid, 0); check("p1_level_f", level, 0);

        // open packet dropped, then a fresh one commits
        put(8'hA0, 0); tick();
        put(8'hA1, 0); tick();
        check("dr_level_a", level, 2); check("dr_rvalid_a", rvalid, 0);
        wvalid = 0; wdrop = 1; tick();
        wdrop = 0;
        check("dr_level_b", level, 0); check("dr_rvalid_b", rvalid, 0);
        put(8'h55, 1); tick();
        wvalid = 0; wlast = 0;
        check("dr_rvalid_c", rvalid, 1); check("dr_data", rdata, 8'h55); check("dr_last", rlast, 1);
        tick();
        check("dr_empty", rvalid, 0); check("dr_level_c", level, 0);

        // fill with single-word packets 0..7
        rready = 0;
        for (int i = 0; i < 8; i++) begin
            put(8'(i), 1); tick();
            check($sformatf("fill_level_%0d", i), level, i + 1);
            check($sformatf("fill_afull_%0d", i), walmost_full, (i + 1) >= 6);
            check($sformatf("fill_wready_%0d", i), wready, (i + 1) != 8);
        end
        put(8'h08, 1);
        rready = 1; tick();
        rready = 0;
        check("full_pop_level", level, 7); check("full_pop_wready", wready, 1);
        check("full_pop_head", rdata, 1);
        tick();
        wvalid = 0; wlast = 0;
        check("full_again_level", level, 8); check("full_again_wready", wready, 0);
        rready = 1;
        for (int v = 1; v <= 8; v++) begin
            check($sformatf("drain_d%0d", v), rdata, v);
            check($sformatf("drain_l%0d", v), rlast, 1);
            check($sformatf("drain_ae%0d", v), ralmost_empty, (9 - v) <= 2);
            tick();
        end
        check("drain_rvalid", rvalid, 0); check("drain_level", level, 0);

        // peek holds the head
        rready = 0;
        put(8'h7E, 1); tick();
        wvalid = 0; wlast = 0;
        rready = 1; rpeek = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("peek_v%0d", i), rvalid, 1);
            check($sformatf("peek_d%0d", i), rdata, 8'h7E);
            check($sformatf("peek_lv%0d", i), level, 1);
        end
        rpeek = 0; tick();
        check("peek_pop_rvalid", rvalid, 0); check("peek_pop_level", level, 0);

        // asynchronous reset with a committed packet and an open one stored
        rready = 0;
        put(8'hC1, 0); tick();
        put(8'hC2, 1); tick();
        put(8'hC3, 0); tick();
        put(8'hC4, 0); tick();
        wvalid = 0; wlast = 0;
        check("ar_pre_level", level, 4); check("ar_pre_rvalid", rvalid, 1);
        #2 areset = 1;
        #1;
        check("ar_level", level, 0); check("ar_rvalid", rvalid, 0);
        check("ar_rdata", rdata, 0); check("ar_wready", wready, 1);
        tick();
        areset = 0;
        tick();
        put(8'h99, 1); tick();
        wvalid = 0; wlast = 0;
        check("ar_post_rvalid", rvalid, 1); check("ar_post_data", rdata, 8'h99);
        check("ar_post_level", level, 1);
        rready = 1; tick();
        check("ar_post_empty", rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
